button_debounce: RTL and testbench

Upstream conditioning stage for the tick latch: takes a raw, asynchronous, bouncing push-button pin and produces a clean, synchronous debounced level, plus single-cycle rise and fall pulses. The output level `o_BTN` drives the `i_BTN` input of `button_tick_latch`. The pulses are available to other OLED control logic, such as mode-step or redraw requests.

---
 rtl/button_debounce.sv | 119 +++++++++++
 tb/tb_button_debounce.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// button_debounce: synchronizes a raw bouncing push-button pin and
// accepts a new level only after it holds for DB_CYCLES cycles.
module button_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 1_000_000,
    parameter int ACTIVE_LOW_IN = 0
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_PIN,
    output logic o_BTN,
    output logic o_RISE,
    output logic o_FALL
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES);

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_H,
        S_HIGH,
        S_WAIT_L
    } state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic btn_q, btn_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic pin_in;
    logic s_sync;

    assign pin_in = (ACTIVE_LOW_IN != 0) ? ~i_PIN : i_PIN;
    assign s_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    end

    // Saturating increment keeps the counter from wrapping.
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        btn_d   = btn_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (s_sync) begin
                    state_d = S_WAIT_H;
                    cnt_d   = '0;
                end
            end
            S_WAIT_H: begin
                if (!s_sync) begin
                    state_d = S_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    btn_d   = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HIGH: begin
                if (!s_sync) begin
                    state_d = S_WAIT_L;
                    cnt_d   = '0;
                end
            end
            S_WAIT_L: begin
                if (s_sync) begin
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    btn_d   = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
                btn_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_BTN  = btn_q;
    assign o_RISE = rise_q;
    assign o_FALL = fall_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed checks of button_debounce with
// DB_CYCLES=4, SYNC_STAGES=2, active-high and active-low instances.
`timescale 1ns/1ps
module tb_button_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic pin, pin_n;
    logic btn, rise, fall;
    logic btn_n, rise_n, fall_n;
    int vectors = 0;
    int miscompares = 0;

    always #1 clk = ~clk;

    button_debounce #(
        .SYNC_STAGES(2), .DB_CYCLES(4), .ACTIVE_LOW_IN(0)
    ) dut (
        .i_CLK(clk), .i_RST(rst_n), .i_PIN(pin),
        .o_BTN(btn), .o_RISE(rise), .o_FALL(fall)
    );

    button_debounce #(
        .SYNC_STAGES(2), .DB_CYCLES(4), .ACTIVE_LOW_IN(1)
    ) dut_n (
        .i_CLK(clk), .i_RST(rst_n), .i_PIN(pin_n),
        .o_BTN(btn_n), .o_RISE(rise_n), .o_FALL(fall_n)
    );

    // One posedge, then settle to the following negedge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pin   = i[0];
            pin_n = ~i[0];
            tick();
            vectors++;
            if ({btn, rise, fall, btn_n, rise_n, fall_n} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_hold i=%0d got=%b want=000000", i,
                         {btn, rise, fall, btn_n, rise_n, fall_n});
            end
        end
        pin   = 1'b0;
        pin_n = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({btn, rise, fall} !== 3'b0) begin
                miscompares++;
                $display("FAIL reset_idle i=%0d got=%b want=000", i,
                         {btn, rise, fall});
            end
        end
    endtask

    task automatic test_clean_press();
        pin = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            vectors++;
            if ({btn, rise, fall} !== {n >= 7, n == 7, 1'b0}) begin
                miscompares++;
                $display("FAIL press n=%0d got=%b want=%b", n,
                         {btn, rise, fall}, {n >= 7, n == 7, 1'b0});
            end
        end
        pin = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            vectors++;
            if ({btn, rise, fall} !== {n < 7, 1'b0, n == 7}) begin
                miscompares++;
                $display("FAIL release n=%0d got=%b want=%b", n,
                         {btn, rise, fall}, {n < 7, 1'b0, n == 7});
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] seq;
        seq = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            pin = seq[i];
            tick();
            vectors++;
            if ({btn, rise, fall} !== 3'b0) begin
                miscompares++;
                $display("FAIL bounce i=%0d got=%b want=000", i,
                         {btn, rise, fall});
            end
        end
        pin = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            vectors++;
            if ({btn, rise, fall} !== {n >= 7, n == 7, 1'b0}) begin
                miscompares++;
                $display("FAIL bounce_hold n=%0d got=%b want=%b", n,
                         {btn, rise, fall}, {n >= 7, n == 7, 1'b0});
            end
        end
        pin = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            vectors++;
            if ({btn, rise, fall} !== {n < 7, 1'b0, n == 7}) begin
                miscompares++;
                $display("FAIL bounce_rel n=%0d got=%b want=%b", n,
                         {btn, rise, fall}, {n < 7, 1'b0, n == 7});
            end
        end
    endtask

    task automatic test_short_glitch();
        for (int n = 1; n <= 12; n++) begin
            pin = (n <= 3);
            tick();
            vectors++;
            if ({btn, rise, fall} !== 3'b0) begin
                miscompares++;
                $display("FAIL glitch3 n=%0d got=%b want=000", n,
                         {btn, rise, fall});
            end
        end
        for (int n = 1; n <= 16; n++) begin
            pin = (n <= 5);
            tick();
            vectors++;
            if ({btn, rise, fall} !==
                {n >= 7 && n < 12, n == 7, n == 12}) begin
                miscompares++;
                $display("FAIL glitch5 n=%0d got=%b want=%b", n,
                         {btn, rise, fall},
                         {n >= 7 && n < 12, n == 7, n == 12});
            end
        end
    endtask

    // Reversal lands on the same edge as the final count.
    task automatic test_simultaneous();
        for (int n = 1; n <= 12; n++) begin
            pin = (n <= 4);
            tick();
            vectors++;
            if ({btn, rise, fall} !== 3'b0) begin
                miscompares++;
                $display("FAIL simult n=%0d got=%b want=000", n,
                         {btn, rise, fall});
            end
        end
    endtask

    task automatic test_wait_reset();
        pin = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #0.2;
        vectors++;
        if ({btn, rise, fall} !== 3'b0) begin
            miscompares++;
            $display("FAIL wait_rst got=%b want=000", {btn, rise, fall});
        end
        pin = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            vectors++;
            if ({btn, rise, fall} !== 3'b0) begin
                miscompares++;
                $display("FAIL wait_rst_after n=%0d got=%b want=000", n,
                         {btn, rise, fall});
            end
        end
    endtask

    task automatic test_held_through_reset();
        pin = 1'b1;
        for (int n = 1; n <= 10; n++) tick();
        vectors++;
        if (btn !== 1'b1) begin
            miscompares++;
            $display("FAIL held_pre got=%b want=1", btn);
        end
        rst_n = 1'b0;
        #0.2;
        vectors++;
        if ({btn, rise, fall} !== 3'b0) begin
            miscompares++;
            $display("FAIL held_async got=%b want=000", {btn, rise, fall});
        end
        for (int n = 1; n <= 3; n++) begin
            tick();
            vectors++;
            if ({btn, rise, fall} !== 3'b0) begin
                miscompares++;
                $display("FAIL held_rst n=%0d got=%b want=000", n,
                         {btn, rise, fall});
            end
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            vectors++;
            if ({btn, rise, fall} !== {n >= 7, n == 7, 1'b0}) begin
                miscompares++;
                $display("FAIL held_post n=%0d got=%b want=%b", n,
                         {btn, rise, fall}, {n >= 7, n == 7, 1'b0});
            end
        end
        pin = 1'b0;
        for (int n = 1; n <= 10; n++) tick();
    endtask

    task automatic test_active_low();
        vectors++;
        if ({btn_n, rise_n, fall_n} !== 3'b0) begin
            miscompares++;
            $display("FAIL alow_idle got=%b want=000",
                     {btn_n, rise_n, fall_n});
        end
        pin_n = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            vectors++;
            if ({btn_n, rise_n, fall_n} !== {n >= 7, n == 7, 1'b0}) begin
                miscompares++;
                $display("FAIL alow_press n=%0d got=%b want=%b", n,
                         {btn_n, rise_n, fall_n}, {n >= 7, n == 7, 1'b0});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        pin   = 1'b0;
        pin_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_glitch();
        test_simultaneous();
        test_wait_reset();
        test_held_through_reset();
        test_active_low();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
